// File: rtl/wf_iq_boxcar.sv
// Post-CIC boxcar averager/decimator for the waterfall I/Q path.
// Sums 2^k samples, then rounds, scales and saturates to the sampler width.
module wf_iq_boxcar #(
  parameter int IN_WIDTH  = 24,
  parameter int OUT_WIDTH = 16,
  parameter int MAX_LOG2N = 4
) (
  input  logic                 adc_clk,
  input  logic                 rst_n,
  input  logic                 set_avg,
  input  logic [2:0]           avg_log2,
  input  logic                 in_strobe,
  input  logic [IN_WIDTH-1:0]  in_i,
  input  logic [IN_WIDTH-1:0]  in_q,
  output logic                 out_strobe,
  output logic [OUT_WIDTH-1:0] out_i,
  output logic [OUT_WIDTH-1:0] out_q,
  output logic                 ovfl,
  input  logic                 clr_ovfl
);

  localparam int AW  = IN_WIDTH + MAX_LOG2N;
  localparam int SH0 = IN_WIDTH - OUT_WIDTH;
  localparam logic [2:0] KMAX = 3'(MAX_LOG2N);
  localparam logic signed [AW:0] ONE = 1;
  localparam logic signed [AW:0] HI =
    (AW+1)'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [AW:0] LO = ~HI;

  logic [2:0]            k;
  logic [2:0]            k_set;
  logic [MAX_LOG2N-1:0]  cnt;
  logic [MAX_LOG2N-1:0]  cnt_last;
  logic                  last;
  logic signed [AW-1:0]  acc_i;
  logic signed [AW-1:0]  acc_q;
  logic signed [AW:0]    sum_i;
  logic signed [AW:0]    sum_q;
  logic signed [AW:0]    half;
  logic [5:0]            sh;
  logic [OUT_WIDTH-1:0]  nxt_i;
  logic [OUT_WIDTH-1:0]  nxt_q;
  logic                  clip_i;
  logic                  clip_q;

  function automatic logic signed [AW:0] ext(
    input logic [IN_WIDTH-1:0] x
  );
    return {{(AW+1-IN_WIDTH){x[IN_WIDTH-1]}}, x};
  endfunction

  // Result is {clip, value}
  function automatic logic [OUT_WIDTH:0] rnd_sat(
    input logic signed [AW:0] x,
    input logic signed [AW:0] h,
    input logic [5:0]         s
  );
    logic signed [AW:0] y;
    y = (x + h) >>> s;
    if (y > HI) return {1'b1, HI[OUT_WIDTH-1:0]};
    if (y < LO) return {1'b1, LO[OUT_WIDTH-1:0]};
    return {1'b0, y[OUT_WIDTH-1:0]};
  endfunction

  always_comb begin
    k_set    = (avg_log2 > KMAX) ? KMAX : avg_log2;
    cnt_last = MAX_LOG2N'((32'd1 << k) - 32'd1);
    last     = (cnt == cnt_last);
    sh       = 6'(k) + 6'(SH0);
    half     = ONE << (sh - 6'd1);
    sum_i    = {acc_i[AW-1], acc_i} + ext(in_i);
    sum_q    = {acc_q[AW-1], acc_q} + ext(in_q);
    {clip_i, nxt_i} = rnd_sat(sum_i, half, sh);
    {clip_q, nxt_q} = rnd_sat(sum_q, half, sh);
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      k          <= '0;
      cnt        <= '0;
      acc_i      <= '0;
      acc_q      <= '0;
      out_strobe <= 1'b0;
      out_i      <= '0;
      out_q      <= '0;
      ovfl       <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      if (clr_ovfl) ovfl <= 1'b0;
      if (set_avg) begin
        k     <= k_set;
        cnt   <= '0;
        acc_i <= '0;
        acc_q <= '0;
      end else if (in_strobe && !last) begin
        acc_i <= sum_i[AW-1:0];
        acc_q <= sum_q[AW-1:0];
        cnt   <= cnt + 1'b1;
      end else if (in_strobe) begin
        acc_i      <= '0;
        acc_q      <= '0;
        cnt        <= '0;
        out_strobe <= 1'b1;
        out_i      <= nxt_i;
        out_q      <= nxt_q;
        // A new clamp outranks a coincident clear
        if (clip_i || clip_q) ovfl <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wf_iq_boxcar.sv
// Self-checking bench for wf_iq_boxcar.
// Directed scenarios plus randomized traffic against a sample-queue model.
module tb_wf_iq_boxcar;

  localparam int IW = 24;
  localparam int OW = 16;
  localparam int ML = 4;

  logic          adc_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          set_avg = 1'b0;
  logic [2:0]    avg_log2 = '0;
  logic          in_strobe = 1'b0;
  logic [IW-1:0] in_i = '0;
  logic [IW-1:0] in_q = '0;
  logic          clr_ovfl = 1'b0;
  logic          out_strobe;
  logic [OW-1:0] out_i;
  logic [OW-1:0] out_q;
  logic          ovfl;

  int checks = 0;
  int passed = 0;

  int            m_k;
  longint        qi[$];
  longint        qq[$];
  logic          e_strobe;
  logic [OW-1:0] e_i;
  logic [OW-1:0] e_q;
  logic          e_ovfl;

  wf_iq_boxcar #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .MAX_LOG2N(ML)
  ) dut (
    .adc_clk(adc_clk), .rst_n(rst_n),
    .set_avg(set_avg), .avg_log2(avg_log2),
    .in_strobe(in_strobe), .in_i(in_i), .in_q(in_q),
    .out_strobe(out_strobe), .out_i(out_i),
    .out_q(out_q), .ovfl(ovfl), .clr_ovfl(clr_ovfl)
  );

  always #5 adc_clk = ~adc_clk;

  function automatic longint sx(input logic [IW-1:0] v);
    return longint'($signed(v));
  endfunction

  // Mean of the block scaled to OW bits, rounded half up
  function automatic logic [OW-1:0] avg(
    input longint s, input int k, output logic clip
  );
    longint d, h, q;
    d = longint'(1) << (k + IW - OW);
    h = s + d / 2;
    q = h / d;
    if (h < 0 && (h % d) != 0) q = q - 1;
    clip = 1'b0;
    if (q > 32767) begin q = 32767; clip = 1'b1; end
    else if (q < -32768) begin q = -32768; clip = 1'b1; end
    return q[OW-1:0];
  endfunction

  task automatic model_reset();
    m_k = 0;
    qi.delete();
    qq.delete();
    e_strobe = 1'b0;
    e_i = '0;
    e_q = '0;
    e_ovfl = 1'b0;
  endtask

  task automatic tick();
    logic ci, cq;
    longint si, sq;
    ci = 1'b0;
    cq = 1'b0;
    e_strobe = 1'b0;
    if (set_avg) begin
      m_k = (avg_log2 > ML) ? ML : int'(avg_log2);
      qi.delete();
      qq.delete();
    end else if (in_strobe) begin
      qi.push_back(sx(in_i));
      qq.push_back(sx(in_q));
      if (qi.size() == (1 << m_k)) begin
        si = 0;
        sq = 0;
        foreach (qi[j]) si += qi[j];
        foreach (qq[j]) sq += qq[j];
        e_i = avg(si, m_k, ci);
        e_q = avg(sq, m_k, cq);
        e_strobe = 1'b1;
        qi.delete();
        qq.delete();
      end
    end
    if (ci || cq) e_ovfl = 1'b1;
    else if (clr_ovfl) e_ovfl = 1'b0;
    @(posedge adc_clk);
    #1;
    set_avg = 1'b0;
    in_strobe = 1'b0;
    clr_ovfl = 1'b0;
  endtask

  task automatic set_k(input int k);
    avg_log2 = 3'(k);
    set_avg = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [IW-1:0] i, input logic [IW-1:0] q);
    in_i = i;
    in_q = q;
    in_strobe = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge adc_clk);
    #1;
    checks++;
    if (out_strobe !== 1'b0) $display("FAIL rst_strobe got %b want 0", out_strobe);
    else passed++;
    checks++;
    if (out_i !== 16'h0 || out_q !== 16'h0)
      $display("FAIL rst_out got %h/%h want 0000/0000", out_i, out_q);
    else passed++;
    checks++;
    if (ovfl !== 1'b0) $display("FAIL rst_ovfl got %b want 0", ovfl);
    else passed++;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_k0();
    strobe(24'h000180, 24'h0);
    checks++;
    if (out_strobe !== 1'b1 || out_i !== 16'h0002)
      $display("FAIL k0_pos got s=%b i=%h want s=1 i=0002", out_strobe, out_i);
    else passed++;
    strobe(24'hFFFE80, 24'h0);
    checks++;
    if (out_strobe !== 1'b1 || out_i !== 16'hFFFF)
      $display("FAIL k0_neg got s=%b i=%h want s=1 i=ffff", out_strobe, out_i);
    else passed++;
    tick();
    checks++;
    if (out_strobe !== 1'b0 || out_i !== 16'hFFFF)
      $display("FAIL k0_hold got s=%b i=%h want s=0 i=ffff", out_strobe, out_i);
    else passed++;
  endtask

  task automatic test_avg4();
    set_k(2);
    for (int n = 1; n <= 4; n++) begin
      strobe(24'h000100, 24'h0);
      checks++;
      if (out_strobe !== (n == 4))
        $display("FAIL avg4_strobe%0d got %b want %b", n, out_strobe, n == 4);
      else passed++;
    end
    checks++;
    if (out_i !== 16'h0001) $display("FAIL avg4_val got %h want 0001", out_i);
    else passed++;
  endtask

  task automatic test_sat();
    set_k(0);
    strobe(24'h7FFFFF, 24'h800000);
    checks++;
    if (out_i !== 16'h7FFF || out_q !== 16'h8000 || ovfl !== 1'b1)
      $display("FAIL sat_i got %h/%h o=%b want 7fff/8000 o=1", out_i, out_q, ovfl);
    else passed++;
    clr_ovfl = 1'b1;
    tick();
    checks++;
    if (ovfl !== 1'b0) $display("FAIL sat_clr got %b want 0", ovfl);
    else passed++;
    strobe(24'h0, 24'h800000);
    checks++;
    if (out_q !== 16'h8000 || ovfl !== 1'b0)
      $display("FAIL sat_qmin got %h o=%b want 8000 o=0", out_q, ovfl);
    else passed++;
    strobe(24'h0, 24'h7FFFFF);
    checks++;
    if (out_q !== 16'h7FFF || ovfl !== 1'b1)
      $display("FAIL sat_qonly got %h o=%b want 7fff o=1", out_q, ovfl);
    else passed++;
    clr_ovfl = 1'b1;
    strobe(24'h7FFFFF, 24'h0);
    checks++;
    if (ovfl !== 1'b1) $display("FAIL sat_clr_vs_clip got %b want 1", ovfl);
    else passed++;
    clr_ovfl = 1'b1;
    tick();
    checks++;
    if (ovfl !== 1'b0) $display("FAIL sat_clr2 got %b want 0", ovfl);
    else passed++;
  endtask

  task automatic test_clamp_k();
    int seen;
    seen = 0;
    set_k(7);
    for (int n = 1; n <= 16; n++) begin
      strobe(24'h0, 24'h001000);
      if (out_strobe === 1'b1) seen++;
    end
    checks++;
    if (seen !== 1 || out_strobe !== 1'b1 || out_q !== 16'h0010)
      $display("FAIL clampk got n=%0d s=%b q=%h want n=1 s=1 q=0010", seen, out_strobe, out_q);
    else passed++;
  endtask

  task automatic test_set_mid();
    int seen;
    logic [OW-1:0] held;
    seen = 0;
    set_k(3);
    for (int n = 0; n < 5; n++) begin
      strobe(24'h000200, 24'h0);
      if (out_strobe === 1'b1) seen++;
    end
    held = out_i;
    avg_log2 = 3'd1;
    set_avg = 1'b1;
    strobe(24'h7FFFFF, 24'h0);
    checks++;
    if (seen !== 0 || out_strobe !== 1'b0 || out_i !== held)
      $display("FAIL setmid_drop got n=%0d s=%b i=%h want n=0 s=0 i=%h", seen, out_strobe, out_i, held);
    else passed++;
    strobe(24'h000200, 24'h0);
    checks++;
    if (out_strobe !== 1'b0) $display("FAIL setmid_first got %b want 0", out_strobe);
    else passed++;
    strobe(24'h000200, 24'h0);
    checks++;
    if (out_strobe !== 1'b1 || out_i !== 16'h0002)
      $display("FAIL setmid_out got s=%b i=%h want s=1 i=0002", out_strobe, out_i);
    else passed++;
  endtask

  task automatic test_reset_mid();
    strobe(24'h000180, 24'h000180);
    set_k(2);
    strobe(24'h000100, 24'h0);
    strobe(24'h000100, 24'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_i !== 16'h0 || out_q !== 16'h0 || out_strobe !== 1'b0 || ovfl !== 1'b0)
      $display("FAIL rstmid got %h/%h s=%b o=%b want 0", out_i, out_q, out_strobe, ovfl);
    else passed++;
    model_reset();
    @(posedge adc_clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_strobe !== 1'b0) $display("FAIL rstmid_idle got %b want 0", out_strobe);
    else passed++;
    strobe(24'h000180, 24'h0);
    checks++;
    if (out_strobe !== 1'b1 || out_i !== 16'h0002)
      $display("FAIL rstmid_k0 got s=%b i=%h want s=1 i=0002", out_strobe, out_i);
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        avg_log2 = 3'($urandom_range(0, 7));
        set_avg = 1'b1;
      end
      in_strobe = ($urandom_range(0, 3) != 0);
      in_i = IW'($urandom);
      in_q = IW'($urandom);
      clr_ovfl = ($urandom_range(0, 19) == 0);
      tick();
      checks++;
      if (out_strobe !== e_strobe || out_i !== e_i || out_q !== e_q || ovfl !== e_ovfl)
        $display("FAIL rand%0d got s=%b %h/%h o=%b want s=%b %h/%h o=%b", n,
                 out_strobe, out_i, out_q, ovfl, e_strobe, e_i, e_q, e_ovfl);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_k0();
    test_avg4();
    test_sat();
    test_clamp_k();
    test_set_mid();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
